cu_multi_cycle: RTL and testbench
=================================

Name: cu_multi_cycle

Overview:
Multi-cycle control unit. It sequences one shared datapath: one ALU, one unified instruction/data memory port, and the IR, OldPC, A/B, ALUOut and Data registers. It implements the same instruction subset as cu_single_cycle (lw, sw, R-type ALU, I-type ALU, beq/bne, jal) using a Moore FSM. Memory access waits on a ready handshake, and the unit traps on unsupported encodings.

Parameters:
MEM_HANDSHAKE, 1, when 1 the memory states wait for mem_ready; when 0, mem_ready is ignored and treated as 1.
STATE_W, 4, width of the state register and of the dbg_state port.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from the IR
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access this cycle
cs_pc_write  out  1  PC register enable
cs_adr_src  out  1  memory address: 0 = PC, 1 = result
cs_ir_write  out  1  IR and OldPC enable
cs_mem_write  out  1  memory write strobe
cs_reg_write  out  1  register file write enable
cs_alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = A
cs_alu_src_b  out  2  00 = B, 01 = imm_ext, 10 = constant 4
cs_result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
cs_imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
cs_alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
instr_retired  out  1  one-cycle pulse in the final cycle of each instruction
illegal_instr  out  1  sticky trap flag
dbg_state  out  STATE_W  current state encoding

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, TRAP 11.
- Reset (rst high at an edge): state goes to FETCH.
  - While rst is high, cs_pc_write, cs_ir_write, cs_mem_write, cs_reg_write, instr_retired and illegal_instr are forced to 0.
  - The remaining outputs show FETCH values.
  - rst mid-instruction abandons the instruction; no write strobe is issued in that cycle.
- Every output defaults to 0 and is asserted only as listed below.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Next state is DECODE if mem_ready=1, otherwise FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_ctrl=add (precomputes the branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_ctrl=add, imm_src=00 for lw and 01 for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, result_src=00. Next state is MEMWB if mem_ready=1, else MEMREAD.
- MEMWB: result_src=01, reg_write=1, retired pulse. Next state FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write held high.
  - On mem_ready=1: retired pulse, next state FETCH.
  - Otherwise: stay in MEMWRITE.
- EXECR: alu_src_a=10, alu_src_b=00. Next state ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00. Next state ALUWB.
- ALU decode in EXECR and EXECI, by funct3:
  - 000: sub if (R-type and funct7_5=1), otherwise add. For I-type, funct7_5 is ignored.
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - any other funct3 -> TRAP instead of ALUWB.
- ALUWB: result_src=00, reg_write=1, retired pulse. Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_ctrl=add, result_src=00, pc_write=1. Next state ALUWB, which writes OldPC+4 to rd.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_ctrl=sub, result_src=00.
  - pc_write = (funct3=000 and zero) or (funct3=001 and not zero).
  - funct3 other than 000/001 -> TRAP instead of FETCH, with pc_write=0.
  - Otherwise: retired pulse, next state FETCH.
- TRAP: illegal_instr=1, all enables 0, no exit except rst.
- Latencies in cycles with mem_ready always 1:
  - lw 5
  - sw 4
  - R/I ALU 4
  - jal 4
  - branch 3
- Each mem_ready=0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready is sampled only in those three states and is ignored elsewhere.

Test Plan:
- rst=1 for 2 cycles, then 0, mem_ready=1 -> during reset all strobes are 0 and dbg_state=0. In the first post-reset cycle, pc_write=1, ir_write=1, result_src=10, alu_src_b=10.
- Sequence lw (0000011), sw (0100011), add (0110011, f3=000, f7_5=0), sub (f7_5=1), addi with f7_5=1 -> dbg_state traces 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,6,7 / 0,1,8,7. alu_ctrl is 000 / 001 / 000 in the execute cycle, and instr_retired pulses once per instruction.
- beq (f3=000) with zero=1, then with zero=0; bne (f3=001) with zero=0 -> BRANCH cycle pc_write is 1, 0, 1, and alu_ctrl=001 in each.
- jal (1101111) -> states 0,1,9,7. pc_write=1 in JAL, reg_write=1 in ALUWB, alu_src_a=01 and alu_src_b=10 in JAL.
- mem_ready=0 for 3 cycles in FETCH, then 2 cycles in MEMWRITE of an sw -> no ir_write or pc_write while stalled. mem_write stays high for 3 cycles, and the sw takes 9 cycles total.
- opcode 1111111, then an R-type with f3=001 -> TRAP reached from DECODE and from EXECR respectively. illegal_instr=1 sticks with no writes until rst, then dbg_state=0.

Source files
------------

// File: rtl/cu_multi_cycle.sv
// Multi-cycle control unit: Moore FSM that sequences the shared ALU, the unified
// memory port and the IR/OldPC/A/B/ALUOut/Data registers for lw, sw, R/I ALU, beq/bne, jal.
module cu_multi_cycle #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               cs_pc_write,
    output logic               cs_adr_src,
    output logic               cs_ir_write,
    output logic               cs_mem_write,
    output logic               cs_reg_write,
    output logic [1:0]         cs_alu_src_a,
    output logic [1:0]         cs_alu_src_b,
    output logic [1:0]         cs_result_src,
    output logic [1:0]         cs_imm_src,
    output logic [2:0]         cs_alu_ctrl,
    output logic               instr_retired,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d, cur;
    logic   ready;
    logic   alu_ok;
    logic [2:0] alu_fn;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    // While reset is held the outputs present FETCH, independent of the stored state.
    assign cur       = rst ? S_FETCH : state_q;
    assign dbg_state = STATE_W'(cur);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        alu_ok = 1'b1;
        alu_fn = ALU_ADD;
        unique case (funct3)
            3'b000:  alu_fn = ((cur == S_EXECR) && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = cur;
        cs_pc_write   = 1'b0;
        cs_adr_src    = 1'b0;
        cs_ir_write   = 1'b0;
        cs_mem_write  = 1'b0;
        cs_reg_write  = 1'b0;
        cs_alu_src_a  = 2'b00;
        cs_alu_src_b  = 2'b00;
        cs_result_src = 2'b00;
        cs_imm_src    = 2'b00;
        cs_alu_ctrl   = ALU_ADD;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;

        case (cur)
            S_FETCH: begin
                cs_alu_src_b  = 2'b10;
                cs_result_src = 2'b10;
                cs_ir_write   = ready;
                cs_pc_write   = ready;
                state_d       = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                cs_alu_src_a = 2'b01;
                cs_alu_src_b = 2'b01;
                cs_imm_src   = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR:        state_d = S_BRANCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                cs_alu_src_a = 2'b10;
                cs_alu_src_b = 2'b01;
                cs_imm_src   = (opcode == OP_SW) ? 2'b01 : 2'b00;
                state_d      = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                cs_adr_src = 1'b1;
                state_d    = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                cs_result_src = 2'b01;
                cs_reg_write  = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                cs_adr_src    = 1'b1;
                cs_mem_write  = 1'b1;
                instr_retired = ready;
                state_d       = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR, S_EXECI: begin
                cs_alu_src_a = 2'b10;
                cs_alu_src_b = (cur == S_EXECI) ? 2'b01 : 2'b00;
                cs_alu_ctrl  = alu_ok ? alu_fn : ALU_ADD;
                state_d      = alu_ok ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                cs_reg_write  = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                cs_alu_src_a = 2'b01;
                cs_alu_src_b = 2'b10;
                cs_pc_write  = 1'b1;
                state_d      = S_ALUWB;
            end
            S_BRANCH: begin
                cs_alu_src_a = 2'b10;
                cs_alu_ctrl  = ALU_SUB;
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    cs_pc_write   = (funct3 == 3'b000) ? zero : ~zero;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_d       = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            cs_pc_write   = 1'b0;
            cs_ir_write   = 1'b0;
            cs_mem_write  = 1'b0;
            cs_reg_write  = 1'b0;
            instr_retired = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_cu_multi_cycle.sv
// Self-checking bench for cu_multi_cycle: an instruction-level model expands each
// instruction into its expected per-cycle trace, which is then replayed against the DUT.
module tb_cu_multi_cycle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       cs_pc_write, cs_adr_src, cs_ir_write, cs_mem_write, cs_reg_write;
    logic [1:0] cs_alu_src_a, cs_alu_src_b, cs_result_src, cs_imm_src;
    logic [2:0] cs_alu_ctrl;
    logic       instr_retired, illegal_instr;
    logic [3:0] dbg_state;

    cu_multi_cycle #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .cs_pc_write(cs_pc_write), .cs_adr_src(cs_adr_src),
        .cs_ir_write(cs_ir_write), .cs_mem_write(cs_mem_write), .cs_reg_write(cs_reg_write),
        .cs_alu_src_a(cs_alu_src_a), .cs_alu_src_b(cs_alu_src_b), .cs_result_src(cs_result_src),
        .cs_imm_src(cs_imm_src), .cs_alu_ctrl(cs_alu_ctrl), .instr_retired(instr_retired),
        .illegal_instr(illegal_instr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic f7; logic z; logic rdy;
        int st; logic pcw, irw, mw, rw, ret; logic [2:0] alu; bit chk_alu;
    } rec_t;

    rec_t q[$];
    logic [6:0] c_op; logic [2:0] c_f3; logic c_f7, c_z;
    int passed = 0, total = 0, fails = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {adr_src, alu_src_a, alu_src_b, result_src, imm_src} in each state.
    function automatic logic [8:0] exp_sel(input int st, input logic [6:0] op);
        case (st)
            0:  return {1'b0, 2'b00, 2'b10, 2'b10, 2'b00};
            1:  return {1'b0, 2'b01, 2'b01, 2'b00, 2'b10};
            2:  return {1'b0, 2'b10, 2'b01, 2'b00, (op == SW) ? 2'b01 : 2'b00};
            3:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            4:  return {1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
            5:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            6:  return {1'b0, 2'b10, 2'b00, 2'b00, 2'b00};
            8:  return {1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
            9:  return {1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
            10: return {1'b0, 2'b10, 2'b00, 2'b00, 2'b00};
            default: return 9'd0;
        endcase
    endfunction

    task automatic push(input int st, input logic rdy, input logic pcw, input logic irw,
                        input logic mw, input logic rw, input logic ret,
                        input logic [2:0] alu, input bit ca);
        rec_t r;
        r.op = c_op; r.f3 = c_f3; r.f7 = c_f7; r.z = c_z; r.rdy = rdy; r.st = st;
        r.pcw = pcw; r.irw = irw; r.mw = mw; r.rw = rw; r.ret = ret; r.alu = alu; r.chk_alu = ca;
        q.push_back(r);
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic trap_cycles(input int n);
        repeat (n) push(11, rnd(), 0, 0, 0, 0, 0, 3'b000, 1);
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input int sf, input int sm);
        logic [2:0] a; bit ok;
        c_op = op; c_f3 = f3; c_f7 = f7; c_z = z;
        repeat (sf) push(0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
        push(0, 1, 1, 1, 0, 0, 0, 3'b000, 1);
        push(1, rnd(), 0, 0, 0, 0, 0, 3'b000, 1);
        if (op == LW) begin
            push(2, rnd(), 0, 0, 0, 0, 0, 3'b000, 1);
            repeat (sm) push(3, 0, 0, 0, 0, 0, 0, 3'b000, 1);
            push(3, 1, 0, 0, 0, 0, 0, 3'b000, 1);
            push(4, rnd(), 0, 0, 0, 1, 1, 3'b000, 1);
        end else if (op == SW) begin
            push(2, rnd(), 0, 0, 0, 0, 0, 3'b000, 1);
            repeat (sm) push(5, 0, 0, 0, 1, 0, 0, 3'b000, 1);
            push(5, 1, 0, 0, 1, 0, 1, 3'b000, 1);
        end else if (op == RT || op == IT) begin
            ok = 1;
            case (f3)
                3'b000:  a = (op == RT && f7) ? 3'b001 : 3'b000;
                3'b010:  a = 3'b101;
                3'b110:  a = 3'b011;
                3'b111:  a = 3'b010;
                default: begin a = 3'b000; ok = 0; end
            endcase
            push((op == RT) ? 6 : 8, rnd(), 0, 0, 0, 0, 0, a, ok);
            if (ok) push(7, rnd(), 0, 0, 0, 1, 1, 3'b000, 1);
            else    trap_cycles(4);
        end else if (op == JL) begin
            push(9, rnd(), 1, 0, 0, 0, 0, 3'b000, 1);
            push(7, rnd(), 0, 0, 0, 1, 1, 3'b000, 1);
        end else if (op == BR) begin
            if (f3 == 3'b000 || f3 == 3'b001) begin
                push(10, rnd(), (f3 == 3'b000) ? z : !z, 0, 0, 0, 1, 3'b001, 1);
            end else begin
                push(10, rnd(), 0, 0, 0, 0, 0, 3'b001, 1);
                trap_cycles(4);
            end
        end else begin
            trap_cycles(4);
        end
    endtask

    task automatic run();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            rst = 1'b0; opcode = r.op; funct3 = r.f3; funct7_5 = r.f7; zero = r.z; mem_ready = r.rdy;
            #1;
            cyc++;
            chk($sformatf("state c%0d", cyc), dbg_state, r.st);
            chk($sformatf("strobes c%0d st%0d", cyc, r.st),
                {cs_pc_write, cs_ir_write, cs_mem_write, cs_reg_write, instr_retired, illegal_instr},
                {r.pcw, r.irw, r.mw, r.rw, r.ret, logic'(r.st == 11)});
            chk($sformatf("sel c%0d st%0d", cyc, r.st),
                {cs_adr_src, cs_alu_src_a, cs_alu_src_b, cs_result_src, cs_imm_src}, exp_sel(r.st, r.op));
            if (r.chk_alu) chk($sformatf("alu c%0d st%0d", cyc, r.st), cs_alu_ctrl, r.alu);
        end
    endtask

    task automatic do_reset();
        repeat (2) begin
            @(negedge clk);
            rst = 1'b1; mem_ready = 1'b1;
            #1;
            chk("rst_strobes",
                {cs_pc_write, cs_ir_write, cs_mem_write, cs_reg_write, instr_retired, illegal_instr}, 6'd0);
            chk("rst_state", dbg_state, 4'd0);
            chk("rst_sel", {cs_adr_src, cs_alu_src_a, cs_alu_src_b, cs_result_src, cs_imm_src},
                exp_sel(0, 7'd0));
        end
    endtask

    initial begin
        logic [2:0] f3s [4];
        int k;
        f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;

        do_reset();
        instr(LW, 3'b010, 0, 0, 0, 0);
        instr(SW, 3'b010, 0, 0, 0, 0);
        instr(RT, 3'b000, 0, 0, 0, 0);
        instr(RT, 3'b000, 1, 0, 0, 0);
        instr(IT, 3'b000, 1, 0, 0, 0);
        instr(BR, 3'b000, 0, 1, 0, 0);
        instr(BR, 3'b000, 0, 0, 0, 0);
        instr(BR, 3'b001, 0, 0, 0, 0);
        instr(JL, 3'b000, 0, 0, 0, 0);
        instr(SW, 3'b010, 0, 0, 3, 2);
        run();

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: instr(LW, 3'b010, rnd(), rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
                1: instr(SW, 3'b010, rnd(), rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
                2: instr(RT, f3s[$urandom_range(0, 3)], rnd(), rnd(), $urandom_range(0, 2), 0);
                3: instr(IT, f3s[$urandom_range(0, 3)], rnd(), rnd(), $urandom_range(0, 2), 0);
                4: instr(JL, 3'(($urandom)), rnd(), rnd(), $urandom_range(0, 2), 0);
                default: instr(BR, {2'b00, rnd()}, rnd(), rnd(), $urandom_range(0, 2), 0);
            endcase
        end
        run();

        // Reset while an sw is stalled in MEMWRITE: the write strobe must drop at once.
        instr(SW, 3'b010, 0, 0, 0, 2);
        void'(q.pop_back());
        void'(q.pop_back());
        run();
        do_reset();

        instr(7'b1111111, 3'b000, 0, 0, 0, 0);
        run();
        do_reset();
        instr(RT, 3'b001, 0, 0, 0, 0);
        run();
        do_reset();
        instr(BR, 3'b100, 0, 1, 0, 0);
        run();
        do_reset();
        instr(RT, 3'b111, 0, 0, 1, 0);
        run();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
